// File: rtl/counter_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer_pkg
// Description : Shared widths and state encoding for the counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_sequencer_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int MAX_W_DEF = 4;

    localparam int ST_W = 2;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CLEAR = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage : counter_sequencer_pkg
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer
// Description : Command-driven controller that runs the prescaled up/down
//               counter until its value matches a commanded target.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int MAX_W = MAX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_dir_i,
    input  logic [MAX_W-1:0] cmd_max_i,
    input  logic [CNT_W-1:0] cmd_target_i,
    input  logic             cmd_clear_i,
    input  logic             abort_i,
    input  logic             pause_i,
    input  logic [CNT_W-1:0] cnt_value_i,
    output logic             cnt_reset_o,
    output logic             cnt_enable_o,
    output logic             cnt_direction_o,
    output logic [MAX_W-1:0] cnt_max_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] step_count_o
);

    state_t             state_q;
    state_t             state_d;
    logic               dir_q;
    logic [MAX_W-1:0]   max_q;
    logic [CNT_W-1:0]   target_q;
    logic [CNT_W-1:0]   step_q;
    logic [CNT_W-1:0]   prev_value_q;
    logic               prev_run_q;

    logic               w_accept;
    logic               w_hit;
    logic               w_step_seen;

    assign w_accept = cmd_valid_i & cmd_ready_o;
    assign w_hit    = (cnt_value_i == target_q);

    // Only compare against a sample also taken in RUN, so the jump caused by a
    // CLEAR (or by anything outside this command) is never counted as a step.
    assign w_step_seen = (state_q == ST_RUN) & prev_run_q & (cnt_value_i != prev_value_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    state_d = cmd_clear_i ? ST_CLEAR : ST_RUN;
                end
            end
            ST_CLEAR: begin
                state_d = abort_i ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (w_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cmd_valid_i) begin
                    state_d = cmd_clear_i ? ST_CLEAR : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o  = 1'b0;
        cnt_reset_o  = 1'b0;
        cnt_enable_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
            end
            ST_CLEAR: begin
                cnt_reset_o = 1'b1;
                busy_o      = 1'b1;
            end
            ST_RUN: begin
                busy_o       = 1'b1;
                // Combinational so the counter is never clocked past the target.
                cnt_enable_o = ~pause_i & ~abort_i & ~w_hit;
            end
            ST_DONE: begin
                cmd_ready_o = 1'b1;
                done_o      = 1'b1;
            end
            default: begin
                cmd_ready_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q        <= 1'b0;
            max_q        <= '0;
            target_q     <= '0;
            step_q       <= '0;
            prev_value_q <= '0;
            prev_run_q   <= 1'b0;
        end else begin
            prev_value_q <= cnt_value_i;
            prev_run_q   <= (state_q == ST_RUN);
            if (w_accept) begin
                dir_q    <= cmd_dir_i;
                max_q    <= cmd_max_i;
                target_q <= cmd_target_i;
                step_q   <= '0;
            end else if (w_step_seen && !(&step_q)) begin
                step_q <= step_q + CNT_W'(1);
            end
        end
    end

    assign cnt_direction_o = dir_q;
    assign cnt_max_o       = max_q;
    assign step_count_o    = step_q;

endmodule : counter_sequencer
`default_nettype wire
